uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_bit_timer.sv | 15 +
 rtl/uart_tx.sv | 113 +++++++++++
 tb/tb_uart_tx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: tx state encoding and stop-bit encodings shared by the uart blocks
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic [1:0] STOP_1 = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2 = 2'b10;
  localparam logic [1:0] STOP_2B = 2'b11;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable down-counter, tick_o high once len_i cycles have elapsed since load
module uart_bit_timer #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i)
    cnt_q <= rst_i ? '0 : load_i ? len_i - 1'b1 : cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
  assign tick_o = cnt_q == '0;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with snapshotted config, 1/1.5/2 stop bits and sticky done flag
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CBP_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CBP_W-1:0]     cbp_i,
  input  logic [1:0]           stop_bits_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_start_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 tx_done_o
);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam int W = CBP_W + 1;
  tx_state_t state_q, state_d;
  logic [CBP_W-1:0] b_q, b_d;
  logic [1:0] stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, start_q;
  logic load, tick;
  logic [W-1:0] len, b_ext, stop_len;
  assign b_ext = {1'b0, b_q};
  assign stop_len = stop_q == STOP_1 ? b_ext : stop_q == STOP_1P5 ? b_ext + (b_ext >> 1) : b_ext << 1;
  uart_bit_timer #(.W(W)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(load),
    .len_i (len),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = done_q;
    bit_d = bit_q;
    sh_d = sh_q;
    b_d = b_q;
    stop_d = stop_q;
    load = 1'b0;
    len = b_ext;
    case (state_q)
      IDLE: if (!start_q && tx_start_i) begin
        state_d = START;
        tx_d = 1'b0;
        busy_d = 1'b1;
        done_d = 1'b0;
        b_d = cbp_i == '0 ? CBP_W'(1) : cbp_i;
        stop_d = stop_bits_i;
        sh_d = tx_data_i;
        load = 1'b1;
        len = {1'b0, b_d};
      end
      START: if (tick) begin
        state_d = DATA;
        tx_d = sh_q[0];
        sh_d = sh_q >> 1;
        bit_d = '0;
        load = 1'b1;
      end
      DATA: if (tick) begin
        load = 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) begin
          state_d = STOP;
          tx_d = 1'b1;
          len = stop_len;
        end else begin
          bit_d = bit_q + 1'b1;
          tx_d = sh_q[0];
          sh_d = sh_q >> 1;
        end
      end
      STOP: if (tick) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bit_q <= '0;
      sh_q <= '0;
      b_q <= '0;
      stop_q <= '0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      b_q <= b_d;
      stop_q <= stop_d;
      start_q <= tx_start_i;
    end
  end
  assign tx_o = tx_q;
  assign busy_o = busy_q;
  assign tx_done_o = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frame vectors plus reset and start-edge corner sequences for uart_tx
module tb_uart_tx;
  import uart_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [15:0] cbp_i = '0;
  logic [1:0] stop_bits_i = '0;
  logic [7:0] tx_data_i = '0;
  logic tx_start_i = 1'b0;
  logic tx_o, busy_o, tx_done_o;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] cbp;
    logic [1:0]  stop;
    logic [7:0]  data;
    int          b;
    int          stopc;
    bit          pert;
  } vec_t;
  vec_t vecs[8];
  always #5 clk_i = ~clk_i;
  uart_tx #(.DATA_BITS(8), .CBP_W(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cbp_i      (cbp_i),
    .stop_bits_i(stop_bits_i),
    .tx_data_i  (tx_data_i),
    .tx_start_i (tx_start_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .tx_done_o  (tx_done_o)
  );
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int exp_tx(input logic [7:0] d, input int b, input int k);
    int i;
    i = (k - 1) / b;
    return i == 0 ? 0 : i <= 8 ? int'(d[i-1]) : 1;
  endfunction
  task automatic frame(input vec_t v, input int id);
    int f;
    f = 9 * v.b + v.stopc;
    cbp_i = v.cbp;
    stop_bits_i = v.stop;
    tx_data_i = v.data;
    tx_start_i = 1'b0;
    tick;
    tx_start_i = 1'b1;
    tick;
    for (int k = 1; k <= f; k++) begin
      chk($sformatf("v%0d tx c%0d", id, k), tx_o, exp_tx(v.data, v.b, k));
      chk($sformatf("v%0d busy c%0d", id, k), busy_o, 1);
      chk($sformatf("v%0d done c%0d", id, k), tx_done_o, 0);
      if (v.pert && k == 3) begin
        tx_data_i = ~v.data;
        cbp_i = v.cbp + 16'd7;
        stop_bits_i = ~v.stop;
        tx_start_i = 1'b0;
      end
      if (v.pert && k == f / 2) tx_start_i = 1'b1;
      tick;
    end
    chk($sformatf("v%0d end busy", id), busy_o, 0);
    chk($sformatf("v%0d end done", id), tx_done_o, 1);
    chk($sformatf("v%0d end tx", id), tx_o, 1);
    repeat (12) tick;
    chk($sformatf("v%0d held busy", id), busy_o, 0);
    chk($sformatf("v%0d held done", id), tx_done_o, 1);
  endtask
  initial begin
    vecs[0] = '{16'd4, STOP_1,   8'hA5, 4, 4,  1'b0};
    vecs[1] = '{16'd0, STOP_1,   8'h00, 1, 1,  1'b0};
    vecs[2] = '{16'd1, STOP_1,   8'h00, 1, 1,  1'b0};
    vecs[3] = '{16'd5, STOP_1P5, 8'h3C, 5, 7,  1'b0};
    vecs[4] = '{16'd5, STOP_2,   8'h81, 5, 10, 1'b0};
    vecs[5] = '{16'd3, STOP_2B,  8'h5A, 3, 6,  1'b1};
    vecs[6] = '{16'd2, STOP_1P5, 8'hFF, 2, 3,  1'b1};
    vecs[7] = '{16'd6, STOP_1,   8'hC3, 6, 6,  1'b1};
    rst_i = 1'b1;
    tx_start_i = 1'b1;
    repeat (3) tick;
    chk("reset tx", tx_o, 1);
    chk("reset busy", busy_o, 0);
    chk("reset done", tx_done_o, 0);
    rst_i = 1'b0;
    repeat (5) tick;
    chk("start held through reset busy", busy_o, 0);
    chk("start held through reset tx", tx_o, 1);
    for (int i = 0; i < 8; i++) frame(vecs[i], i);
    cbp_i = 16'd1;
    stop_bits_i = STOP_1;
    tx_data_i = 8'h55;
    tx_start_i = 1'b0;
    tick;
    tx_start_i = 1'b1;
    tick;
    tx_start_i = 1'b0;
    repeat (9) tick;
    chk("last stop busy", busy_o, 1);
    chk("last stop tx", tx_o, 1);
    tx_start_i = 1'b1;
    tick;
    chk("edge at busy fall busy", busy_o, 0);
    chk("edge at busy fall done", tx_done_o, 1);
    repeat (5) tick;
    chk("edge at busy fall ignored", busy_o, 0);
    cbp_i = 16'd2;
    tx_data_i = 8'h00;
    tx_start_i = 1'b0;
    tick;
    tx_start_i = 1'b1;
    tick;
    repeat (7) tick;
    chk("mid data tx", tx_o, 0);
    chk("mid data busy", busy_o, 1);
    rst_i = 1'b1;
    tick;
    chk("abort tx", tx_o, 1);
    chk("abort busy", busy_o, 0);
    chk("abort done", tx_done_o, 0);
    rst_i = 1'b0;
    repeat (25) tick;
    chk("post abort busy", busy_o, 0);
    chk("post abort tx", tx_o, 1);
    chk("post abort done", tx_done_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
